// File: rtl/imu_pkg.sv
// ============================================================================
// Module   : imu_pkg
// Purpose  : Sample/frame types and slot layout for the IMU frame assembler.
//            Layout depends on macro IMU_TEMP_EN (defined: 7-word burst with temp).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imu_pkg;

`ifdef IMU_TEMP_EN
  localparam int FRAME_WORDS = 7;

  typedef enum logic [2:0] {
    SLOT_TEMP    = 3'd0,
    SLOT_GYRO_X  = 3'd1,
    SLOT_GYRO_Y  = 3'd2,
    SLOT_GYRO_Z  = 3'd3,
    SLOT_ACCEL_X = 3'd4,
    SLOT_ACCEL_Y = 3'd5,
    SLOT_ACCEL_Z = 3'd6
  } imu_slot_e;
`else
  localparam int FRAME_WORDS = 6;

  typedef enum logic [2:0] {
    SLOT_GYRO_X  = 3'd0,
    SLOT_GYRO_Y  = 3'd1,
    SLOT_GYRO_Z  = 3'd2,
    SLOT_ACCEL_X = 3'd3,
    SLOT_ACCEL_Y = 3'd4,
    SLOT_ACCEL_Z = 3'd5
  } imu_slot_e;
`endif

  localparam int SLOT_W = 3;

  typedef logic [FRAME_WORDS-1:0][15:0] imu_frame_t;

  typedef struct packed {
    logic signed [15:0] temp;
    logic signed [15:0] gyro_x;
    logic signed [15:0] gyro_y;
    logic signed [15:0] gyro_z;
    logic signed [15:0] accel_x;
    logic signed [15:0] accel_y;
    logic signed [15:0] accel_z;
  } imu_sample_t;

  // Sensor shifts the low byte out first.
  function automatic logic [15:0] swap_bytes(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic imu_sample_t frame_to_sample(input imu_frame_t f);
    imu_sample_t s;
    s = '0;
`ifdef IMU_TEMP_EN
    s.temp = f[SLOT_TEMP];
`endif
    s.gyro_x  = f[SLOT_GYRO_X];
    s.gyro_y  = f[SLOT_GYRO_Y];
    s.gyro_z  = f[SLOT_GYRO_Z];
    s.accel_x = f[SLOT_ACCEL_X];
    s.accel_y = f[SLOT_ACCEL_Y];
    s.accel_z = f[SLOT_ACCEL_Z];
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imu_frame_assembler_gap_timer.sv
// ============================================================================
// Module   : gap_timer
// Purpose  : Counts idle cycles while enabled; pulses expire on the
//            TIMEOUT_CYCLES-th cycle without a load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expire_o = enable_i & ~load_i & (count_q == C_LAST);

  always_comb begin
    count_d = '0;
    if (enable_i && !load_i && !expire_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imu_frame_assembler.sv
// ============================================================================
// Module   : imu_frame_assembler
// Purpose  : Assembles byte-swapped SPI burst words into one IMU sample with a
//            valid/ready output register. Macro IMU_TEMP_EN adds the temp slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imu_frame_assembler
  import imu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       word_in,
  input  logic              word_valid,
  input  logic              frame_start,
  output imu_sample_t       sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam logic [0:0]        ST_IDLE    = 1'b0;
  localparam logic [0:0]        ST_COLLECT = 1'b1;
  localparam logic [SLOT_W-1:0] C_LAST_IDX = SLOT_W'(FRAME_WORDS - 1);

  logic [0:0]        state_q,   state_d;
  logic [SLOT_W-1:0] idx_q,     idx_d;
  imu_frame_t        slots_q,   slots_d;
  imu_sample_t       sample_q,  sample_d;
  logic              valid_q,   valid_d;
  logic              overrun_q, overrun_d;
  logic              err_q,     err_d;
  logic [15:0]       count_q,   count_d;

  logic [15:0] w_swapped;
  logic        w_in_collect;
  logic        w_complete;
  logic        w_handshake;
  logic        w_load;
  logic        w_expire;

  assign w_swapped    = swap_bytes(word_in);
  assign w_in_collect = (state_q == ST_COLLECT);
  assign w_complete   = w_in_collect & word_valid & ~frame_start & (idx_q == C_LAST_IDX);
  assign w_handshake  = valid_q & sample_ready;
  assign w_load       = frame_start | (w_in_collect & word_valid);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .enable_i(w_in_collect),
    .expire_o(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (frame_start)                 state_d = ST_COLLECT;
        else if (w_complete || w_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    slots_d   = slots_q;
    err_d     = err_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    count_d   = count_q;

    // A restart takes priority; a word arriving with it becomes slot 0.
    if (frame_start) begin
      idx_d = '0;
      if (w_in_collect && (idx_q != '0)) err_d = 1'b1;
      if (word_valid) begin
        slots_d[0] = w_swapped;
        idx_d      = SLOT_W'(1);
      end
    end else if (w_in_collect && word_valid) begin
      slots_d[idx_q] = w_swapped;
      idx_d          = w_complete ? '0 : idx_q + SLOT_W'(1);
    end else if (w_expire) begin
      err_d = 1'b1;
      idx_d = '0;
    end

    if (w_complete && (!valid_q || w_handshake)) begin
      sample_d = frame_to_sample(slots_d);
      valid_d  = 1'b1;
      count_d  = count_q + 16'd1;
    end else if (w_complete) begin
      overrun_d = 1'b1;
    end else if (w_handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      slots_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      idx_q     <= idx_d;
      slots_q   <= slots_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = err_q;
  assign frame_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_imu_frame_assembler.sv
// ============================================================================
// Module   : tb_imu_frame_assembler
// Purpose  : Self-checking bench for imu_frame_assembler (both IMU_TEMP_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imu_frame_assembler;
  import imu_pkg::*;

  localparam int TO    = 16;
  localparam int FIRST = 7 - FRAME_WORDS;

  typedef logic [15:0] frame7_t [7];

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word_in;
  logic        word_valid;
  logic        frame_start;
  imu_sample_t sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        frame_err;
  logic [15:0] frame_count;

  int n_checks  = 0;
  int n_fail    = 0;
  int exp_count = 0;
  imu_sample_t exp_q[$];

  always #5 clk = ~clk;

  imu_frame_assembler #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .frame_start (frame_start),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  function automatic logic [15:0] bswap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic imu_sample_t model(input frame7_t f);
    imu_sample_t s;
`ifdef IMU_TEMP_EN
    s.temp = bswap(f[0]);
`else
    s.temp = 16'h0000;
`endif
    s.gyro_x  = bswap(f[1]);
    s.gyro_y  = bswap(f[2]);
    s.gyro_z  = bswap(f[3]);
    s.accel_x = bswap(f[4]);
    s.accel_y = bswap(f[5]);
    s.accel_z = bswap(f[6]);
    return s;
  endfunction

  // Handshake monitor: every accepted sample must match the scoreboard head.
  always @(negedge clk) begin : mon
    imu_sample_t e;
    if (!rst && sample_valid && sample_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got sample %h, expected no sample", sample_out);
      end else begin
        e = exp_q.pop_front();
        if (sample_out !== e) begin
          n_fail++;
          $display("FAIL sb_sample: got %h, expected %h", sample_out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic fs);
    word_in     = w;
    word_valid  = 1'b1;
    frame_start = fs;
    step();
    word_valid  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input frame7_t f, input bit push);
    if (push) begin
      exp_q.push_back(model(f));
      exp_count++;
    end
    pulse_start();
    for (int i = FIRST; i < 7; i++) send_word(f[i], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (sample_out !== '0 || sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got out=%h valid=%b, expected 0/0", sample_out, sample_valid);
    end
    n_checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got ovr=%b err=%b cnt=%0d, expected 0/0/0",
               overrun, frame_err, frame_count);
    end
  endtask

  task automatic test_basic();
    frame7_t     a;
    imu_sample_t k;
    a = '{16'h3412, 16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'hFEFF, 16'h0040};
`ifdef IMU_TEMP_EN
    k.temp = 16'h1234;
`else
    k.temp = 16'h0000;
`endif
    k.gyro_x = 16'h0001; k.gyro_y = 16'h0002; k.gyro_z = 16'h0003;
    k.accel_x = 16'h00FF; k.accel_y = 16'hFFFE; k.accel_z = 16'h4000;
    sample_ready = 1'b1;
    exp_q.push_back(model(a));
    exp_count++;
    pulse_start();
    for (int i = FIRST; i < 6; i++) send_word(a[i], 1'b0);
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: got valid=%b before last word, expected 0", sample_valid);
    end
    send_word(a[6], 1'b0);
    n_checks++;
    if (sample_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got valid=%b after last word, expected 1", sample_valid);
    end
    n_checks++;
    if (sample_out !== k) begin
      n_fail++;
      $display("FAIL basic_fields: got %h, expected %h", sample_out, k);
    end
    n_checks++;
    if (frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d, expected 1", frame_count);
    end
    step();
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consume: got valid=%b, expected 0", sample_valid);
    end
  endtask

  task automatic test_overrun();
    frame7_t b, c;
    b = '{16'h1100, 16'h2200, 16'h3300, 16'h4400, 16'h5500, 16'h6600, 16'h7700};
    c = '{16'hAA01, 16'hBB02, 16'hCC03, 16'hDD04, 16'hEE05, 16'hFF06, 16'h0107};
    sample_ready = 1'b0;
    send_frame(b, 1'b1);
    send_frame(c, 1'b0);
    n_checks++;
    if (sample_valid !== 1'b1 || sample_out !== model(b)) begin
      n_fail++;
      $display("FAIL ovr_hold: got valid=%b out=%h, expected 1/%h", sample_valid, sample_out, model(b));
    end
    n_checks++;
    if (overrun !== 1'b1 || frame_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL ovr_flags: got ovr=%b cnt=%0d, expected 1/%0d", overrun, frame_count, exp_count);
    end
    sample_ready = 1'b1;
    step();
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_release: got valid=%b, expected 0", sample_valid);
    end
  endtask

  task automatic test_restart();
    frame7_t d;
    d = '{16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 16'h1213, 16'h1415, 16'h1617};
    do_reset();
    sample_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(16'hDEAD, 1'b0);
    send_frame(d, 1'b1);
    n_checks++;
    if (frame_err !== 1'b1 || sample_valid !== 1'b1 || sample_out !== model(d)) begin
      n_fail++;
      $display("FAIL restart: got err=%b valid=%b out=%h, expected 1/1/%h",
               frame_err, sample_valid, sample_out, model(d));
    end
    step();
  endtask

  task automatic test_back_to_back();
    frame7_t e, f;
    e = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E};
    f = '{16'hF0E0, 16'hD0C0, 16'hB0A0, 16'h9080, 16'h7060, 16'h5040, 16'h3020};
    do_reset();
    sample_ready = 1'b0;
    exp_q.push_back(model(e));
    exp_count++;
    // First word rides on the frame_start pulse.
    send_word(e[FIRST], 1'b1);
    for (int i = FIRST + 1; i < 7; i++) send_word(e[i], 1'b0);
    exp_q.push_back(model(f));
    exp_count++;
    pulse_start();
    for (int i = FIRST; i < 6; i++) send_word(f[i], 1'b0);
    sample_ready = 1'b1;
    send_word(f[6], 1'b0);
    n_checks++;
    if (sample_valid !== 1'b1 || sample_out !== model(f)) begin
      n_fail++;
      $display("FAIL b2b_load: got valid=%b out=%h, expected 1/%h", sample_valid, sample_out, model(f));
    end
    n_checks++;
    if (overrun !== 1'b0 || frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_flags: got ovr=%b cnt=%0d, expected 0/2", overrun, frame_count);
    end
    step();
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got valid=%b, expected 0", sample_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    sample_ready = 1'b1;
    pulse_start();
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    repeat (TO - 1) step();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got err=%b after %0d idle cycles, expected 0", frame_err, TO - 1);
    end
    step();
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: got err=%b after %0d idle cycles, expected 1", frame_err, TO);
    end
    for (int i = 0; i < 7; i++) send_word(16'h5A5A + 16'(i), 1'b0);
    step();
    n_checks++;
    if (sample_valid !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL timeout_idle: got valid=%b cnt=%0d, expected 0/0", sample_valid, frame_count);
    end
  endtask

  task automatic test_reset_mid();
    frame7_t g;
    g = '{16'h7F00, 16'h0080, 16'hFF7F, 16'h0101, 16'h2020, 16'h3030, 16'h4040};
    sample_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(16'hBEEF, 1'b0);
    do_reset();
    n_checks++;
    if (sample_out !== '0 || sample_valid !== 1'b0 || overrun !== 1'b0 ||
        frame_err !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got out=%h valid=%b ovr=%b err=%b cnt=%0d, expected all 0",
               sample_out, sample_valid, overrun, frame_err, frame_count);
    end
    send_frame(g, 1'b1);
    n_checks++;
    if (sample_valid !== 1'b1 || frame_err !== 1'b0 || frame_count !== 16'd1 ||
        sample_out !== model(g)) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got valid=%b err=%b cnt=%0d out=%h, expected 1/0/1/%h",
               sample_valid, frame_err, frame_count, sample_out, model(g));
    end
    step();
  endtask

  initial begin
    rst          = 1'b1;
    word_in      = '0;
    word_valid   = 1'b0;
    frame_start  = 1'b0;
    sample_ready = 1'b0;

    test_reset();
    test_basic();
    test_overrun();
    test_restart();
    test_back_to_back();
    test_timeout();
    test_reset_mid();

    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d samples left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
